// File: rtl/mmpu_pkg.sv
// Shared definitions for the mMPU command dispatcher: command field layout,
// op and FSM state encodings, and the per-op crossbar cycle count.
package mmpu_pkg;

    localparam int CMD_W   = 34;
    localparam int OP_LSB  = 32;
    localparam int OP_W    = 2;
    localparam int IDX_LSB = 26;
    localparam int IDX_W   = 6;
    localparam int ROW_LSB = 16;
    localparam int ROW_W   = 10;
    localparam int COL_LSB = 6;
    localparam int COL_W   = 10;
    localparam int AUX_LSB = 0;
    localparam int AUX_W   = 6;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_MAGIC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        RESP   = 2'b10
    } state_e;

    // MAGIC carries its evaluate length minus one in aux, so 0..63 maps to 1..64 cycles.
    function automatic logic [CNT_W-1:0] op_cycles(input op_e op, input logic [AUX_W-1:0] aux,
                                                    input int wr_cycles, input int rd_cycles);
        logic [CNT_W-1:0] n;
        case (op)
            OP_WRITE: n = CNT_W'(wr_cycles);
            OP_READ:  n = CNT_W'(rd_cycles);
            OP_MAGIC: n = {1'b0, aux} + 7'd1;
            default:  n = 7'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mmpu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count; full/empty are
// decoded from that count so they never depend on the current push/pop.
module mmpu_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/mmpu_cmd_dispatcher.sv
// Buffers mMPU commands and sequences each one into timed crossbar control,
// returning sensed data for READs on an AXIS-style response channel.
module mmpu_cmd_dispatcher
    import mmpu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int CROSSBAR_WIDTH = 16,
    parameter int WRITE_CYCLES   = 4,
    parameter int READ_CYCLES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CMD_W-1:0]          s_axis_mMPU_command,
    input  logic                      s_axis_valid_mMPU_command,
    output logic                      s_axis_ready_mMPU_command,
    output logic                      xb_en,
    output logic [OP_W-1:0]           xb_op,
    output logic [IDX_W-1:0]          xb_idx,
    output logic [ROW_W-1:0]          xb_row,
    output logic [COL_W-1:0]          xb_col,
    input  logic [CROSSBAR_WIDTH-1:0] xb_rdata,
    output logic [CROSSBAR_WIDTH-1:0] m_axis_rd_data,
    output logic                      m_axis_valid_rd_data,
    input  logic                      m_axis_ready_rd_data,
    output logic                      busy,
    output logic [15:0]               cmd_count
);

    localparam int CW = $clog2(FIFO_DEPTH);

    logic [CMD_W-1:0]          fifo_dout_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [CW:0]               fifo_count_s;
    logic                      pop_s;
    op_e                       head_op_s;

    state_e                    state_r, state_nx_s;
    logic [CNT_W-1:0]          cnt_r, cnt_nx_s;
    logic                      load_s, done_s, cap_s, acc_s;

    op_e                       op_r;
    logic [IDX_W-1:0]          idx_r;
    logic [ROW_W-1:0]          row_r;
    logic [COL_W-1:0]          col_r;

    logic                      xb_en_r;
    logic [OP_W-1:0]           xb_op_r;
    logic [IDX_W-1:0]          xb_idx_r;
    logic [ROW_W-1:0]          xb_row_r;
    logic [COL_W-1:0]          xb_col_r;
    logic [CROSSBAR_WIDTH-1:0] rd_data_r;
    logic                      rd_valid_r;
    logic [15:0]               cmd_count_r;

    mmpu_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_axis_valid_mMPU_command),
        .din   (s_axis_mMPU_command),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign head_op_s = op_e'(fifo_dout_s[OP_LSB +: OP_W]);

    // Dispatch FSM: pop in IDLE, count down in ACTIVE, hold the READ response in RESP.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        pop_s      = 1'b0;
        load_s     = 1'b0;
        done_s     = 1'b0;
        cap_s      = 1'b0;
        acc_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_op_s == OP_NOP) begin
                        done_s = 1'b1;
                    end else begin
                        load_s     = 1'b1;
                        cnt_nx_s   = op_cycles(head_op_s, fifo_dout_s[AUX_LSB +: AUX_W],
                                               WRITE_CYCLES, READ_CYCLES);
                        state_nx_s = ACTIVE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cnt_r == 7'd1) begin
                    if (op_r == OP_READ) begin
                        state_nx_s = RESP;
                    end else begin
                        done_s     = 1'b1;
                        state_nx_s = IDLE;
                    end
                end else begin
                    cnt_nx_s = cnt_r - 7'd1;
                end
            end
            RESP: begin
                // xb_en trails the state by a cycle, so the first RESP cycle is the last sensed cycle.
                if (!rd_valid_r) begin
                    cap_s = 1'b1;
                end else if (m_axis_ready_rd_data) begin
                    acc_s      = 1'b1;
                    done_s     = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state and op cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 7'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Command fields latched at pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r  <= OP_NOP;
            idx_r <= 6'd0;
            row_r <= 10'd0;
            col_r <= 10'd0;
        end else if (load_s) begin
            op_r  <= head_op_s;
            idx_r <= fifo_dout_s[IDX_LSB +: IDX_W];
            row_r <= fifo_dout_s[ROW_LSB +: ROW_W];
            col_r <= fifo_dout_s[COL_LSB +: COL_W];
        end
    end

    // Crossbar drive: selects update only together with xb_en so they hold between ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xb_en_r  <= 1'b0;
            xb_op_r  <= 2'b00;
            xb_idx_r <= 6'd0;
            xb_row_r <= 10'd0;
            xb_col_r <= 10'd0;
        end else begin
            xb_en_r <= (state_r == ACTIVE);
            if (state_r == ACTIVE) begin
                xb_op_r  <= op_r;
                xb_idx_r <= idx_r;
                xb_row_r <= row_r;
                xb_col_r <= col_r;
            end
        end
    end

    // READ response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (cap_s) begin
            rd_data_r  <= xb_rdata;
            rd_valid_r <= 1'b1;
        end else if (acc_s) begin
            rd_valid_r <= 1'b0;
        end
    end

    // Completed-command counter, wraps at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_count_r <= 16'd0;
        end else if (done_s) begin
            cmd_count_r <= cmd_count_r + 16'd1;
        end
    end

    assign s_axis_ready_mMPU_command = ~fifo_full_s;
    assign xb_en                     = xb_en_r;
    assign xb_op                     = xb_op_r;
    assign xb_idx                    = xb_idx_r;
    assign xb_row                    = xb_row_r;
    assign xb_col                    = xb_col_r;
    assign m_axis_rd_data            = rd_data_r;
    assign m_axis_valid_rd_data      = rd_valid_r;
    assign cmd_count                 = cmd_count_r;
    assign busy = (state_r != IDLE) | (fifo_count_s != (CW+1)'(0)) | xb_en_r;

endmodule

// File: tb/tb_mmpu_cmd_dispatcher.sv
// Scoreboard bench for mmpu_cmd_dispatcher: expected crossbar ops and READ
// responses are queued at command acceptance and compared as the DUT emits them.
module tb_mmpu_cmd_dispatcher;

    localparam int WR_CYC = 4;
    localparam int RD_CYC = 2;

    typedef struct {
        logic [1:0] op;
        logic [5:0] idx;
        logic [9:0] row;
        logic [9:0] col;
        int         len;
    } exp_op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] cmd;
    logic        cmd_valid;
    logic        s_ready;
    logic        xb_en;
    logic [1:0]  xb_op;
    logic [5:0]  xb_idx;
    logic [9:0]  xb_row, xb_col;
    logic [15:0] xb_rdata;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic [15:0] cmd_count;

    exp_op_t     op_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] rdata_q[$];

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int unexp_ops = 0;
    int unexp_rsp = 0;

    mmpu_cmd_dispatcher #(
        .FIFO_DEPTH(8), .CROSSBAR_WIDTH(16), .WRITE_CYCLES(WR_CYC), .READ_CYCLES(RD_CYC)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_axis_mMPU_command       (cmd),
        .s_axis_valid_mMPU_command (cmd_valid),
        .s_axis_ready_mMPU_command (s_ready),
        .xb_en                     (xb_en),
        .xb_op                     (xb_op),
        .xb_idx                    (xb_idx),
        .xb_row                    (xb_row),
        .xb_col                    (xb_col),
        .xb_rdata                  (xb_rdata),
        .m_axis_rd_data            (rd_data),
        .m_axis_valid_rd_data      (rd_valid),
        .m_axis_ready_rd_data      (rd_ready),
        .busy                      (busy),
        .cmd_count                 (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [33:0] mk_cmd(input logic [1:0] op, input logic [5:0] idx,
                                           input logic [9:0] row, input logic [9:0] col,
                                           input logic [5:0] aux);
        return {op, idx, row, col, aux};
    endfunction

    task automatic sb_add(input logic [1:0] op, input logic [5:0] idx, input logic [9:0] row,
                          input logic [9:0] col, input logic [5:0] aux, input logic [15:0] rval);
        exp_op_t e;
        exp_cnt++;
        if (op != 2'b00) begin
            e.op  = op;
            e.idx = idx;
            e.row = row;
            e.col = col;
            case (op)
                2'b01:   e.len = WR_CYC;
                2'b10:   e.len = RD_CYC;
                default: e.len = int'(aux) + 1;
            endcase
            op_q.push_back(e);
        end
        if (op == 2'b10) begin
            rsp_q.push_back(rval);
            rdata_q.push_back(rval);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [5:0] idx, input logic [9:0] row,
                        input logic [9:0] col, input logic [5:0] aux, input logic [15:0] rval);
        int n = 0;
        cmd       = mk_cmd(op, idx, row, col, aux);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", s_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        sb_add(op, idx, row, col, aux, rval);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || xb_en || rd_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
        check("cmd_count", cmd_count, exp_cnt);
        @(posedge clk);
        #1;
    endtask

    // Crossbar model: measures each xb_en pulse, drives sensed data, checks against the op queue.
    int          en_len = 0;
    logic        prev_en = 1'b0;
    logic        sel_chg = 1'b0;
    logic [27:0] m_sel;
    always @(negedge clk) begin
        exp_op_t e;
        if (rst) begin
            en_len   = 0;
            prev_en  = 1'b0;
            sel_chg  = 1'b0;
            xb_rdata = 16'h0000;
        end else begin
            if (xb_en) begin
                if (prev_en && ({xb_op, xb_idx, xb_row, xb_col} != m_sel)) sel_chg = 1'b1;
                m_sel = {xb_op, xb_idx, xb_row, xb_col};
                en_len++;
                if (xb_op == 2'b10 && en_len == RD_CYC && rdata_q.size() > 0)
                    xb_rdata = rdata_q.pop_front();
                else
                    xb_rdata = 16'h5A5A;
            end else begin
                xb_rdata = 16'h0000;
                if (prev_en) begin
                    if (op_q.size() == 0) begin
                        unexp_ops++;
                    end else begin
                        e = op_q.pop_front();
                        check("xb_op", m_sel[27:26], e.op);
                        check("xb_idx", m_sel[25:20], e.idx);
                        check("xb_row", m_sel[19:10], e.row);
                        check("xb_col", m_sel[9:0], e.col);
                        check("xb_en_len", en_len, e.len);
                        check("sel_stable", sel_chg, 1'b0);
                    end
                    en_len  = 0;
                    sel_chg = 1'b0;
                end
            end
            prev_en = xb_en;
        end
    end

    // Response monitor: a valid&ready sample means the next edge completes the handshake.
    always @(negedge clk) begin
        logic [15:0] r;
        if (!rst && rd_valid && rd_ready) begin
            if (rsp_q.size() == 0) begin
                unexp_rsp++;
            end else begin
                r = rsp_q.pop_front();
                check("rsp_data", rd_data, r);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int q;
        int n;
        rst       = 1'b1;
        cmd       = 34'd0;
        cmd_valid = 1'b0;
        rd_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", s_ready, 1'b1);
        check("rst_xb_en", xb_en, 1'b0);
        check("rst_idx", xb_idx, 6'd0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", cmd_count, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // WRITE xb4 row0 col65 with exact xb_en timing
        push(2'b01, 6'd4, 10'd0, 10'd65, 6'd0, 16'h0);
        @(negedge clk);
        check("lat_k", xb_en, 1'b0);
        @(negedge clk);
        check("lat_k1", xb_en, 1'b0);
        @(negedge clk);
        check("lat_k2", xb_en, 1'b1);
        wait_idle("idle_write");

        // READ with a stalled consumer
        rd_ready = 1'b0;
        push(2'b10, 6'd9, 10'd300, 10'd17, 6'd0, 16'hBEEF);
        n = 0;
        @(negedge clk);
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_valid_rise", rd_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rd_hold_valid", rd_valid, 1'b1);
            check("rd_hold_data", rd_data, 16'hBEEF);
        end
        check("rd_cnt_before", cmd_count, exp_cnt - 1);
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        @(negedge clk);
        check("rd_valid_6th", rd_valid, 1'b1);
        @(negedge clk);
        check("rd_valid_drop", rd_valid, 1'b0);
        check("rd_cnt_after", cmd_count, exp_cnt);
        @(posedge clk);
        #1;

        // MAGIC at the longest evaluate length, then NOP
        push(2'b11, 6'd2, 10'd5, 10'd7, 6'd63, 16'h0);
        wait_idle("idle_magic");
        push(2'b00, 6'd0, 10'd0, 10'd0, 6'd0, 16'h0);
        @(negedge clk);
        check("nop_pre", cmd_count, exp_cnt - 1);
        @(negedge clk);
        check("nop_post", cmd_count, exp_cnt);
        @(posedge clk);
        #1;

        // Fill the FIFO behind a stalled READ; ninth WRITE waits for a pop
        rd_ready = 1'b0;
        push(2'b10, 6'd1, 10'd2, 10'd3, 6'd0, 16'h1234);
        for (int i = 0; i < 8; i++)
            push(2'b01, 6'(i + 8), 10'(i * 3 + 1), 10'(i + 100), 6'd0, 16'h0);
        @(negedge clk);
        check("full_ready", s_ready, 1'b0);
        fork
            push(2'b01, 6'd20, 10'd999, 10'd512, 6'd0, 16'h0);
            begin
                repeat (3) @(negedge clk);
                check("full_hold", s_ready, 1'b0);
                @(posedge clk);
                #1;
                rd_ready = 1'b1;
            end
        join
        wait_idle("idle_fill");

        // Push and pop on the same edge at count = depth-1
        rd_ready = 1'b0;
        push(2'b10, 6'd3, 10'd4, 10'd5, 6'd0, 16'h0F0F);
        for (int i = 0; i < 7; i++)
            push(2'b01, 6'(i + 30), 10'(i + 40), 10'(i + 50), 6'd0, 16'h0);
        rd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd       = mk_cmd(2'b01, 6'd60, 10'd61, 10'd62, 6'd0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        sb_add(2'b01, 6'd60, 10'd61, 10'd62, 6'd0, 16'h0);
        cmd = mk_cmd(2'b01, 6'd61, 10'd63, 10'd64, 6'd0);
        @(negedge clk);
        check("pushpop_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;
        sb_add(2'b01, 6'd61, 10'd63, 10'd64, 6'd0, 16'h0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pushpop_full", s_ready, 1'b0);
        @(posedge clk);
        #1;
        wait_idle("idle_pushpop");

        // Reset during a READ with three commands queued
        push(2'b10, 6'd7, 10'd8, 10'd9, 6'd0, 16'hAAAA);
        for (int i = 0; i < 3; i++)
            push(2'b01, 6'(i + 1), 10'd1, 10'd1, 6'd0, 16'h0);
        check("pre_rst_en", xb_en, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_xb_en", xb_en, 1'b0);
        check("abort_valid", rd_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_count", cmd_count, 16'd0);
        check("abort_ready", s_ready, 1'b1);
        op_q.delete();
        rsp_q.delete();
        rdata_q.delete();
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q = 0;
        repeat (10) begin
            @(negedge clk);
            if (xb_en || rd_valid || busy) q++;
        end
        check("post_rst_quiet", q, 0);
        @(posedge clk);
        #1;
        push(2'b01, 6'd5, 10'd6, 10'd7, 6'd0, 16'h0);
        wait_idle("idle_after_rst");

        check("unexpected_ops", unexp_ops, 0);
        check("unexpected_rsp", unexp_rsp, 0);
        check("ops_pending", op_q.size(), 0);
        check("rsp_pending", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
